jt12_dac_fifo: RTL and testbench

JT12_DAC_FIFO -- requirements
Module: jt12_dac_fifo

---
 rtl/jt12_pcm_pkg.sv | 16 +
 rtl/jt12_dac_fifo_mem.sv | 54 +++++
 rtl/jt12_dac_fifo.sv | 106 ++++++++++
 tb/tb_jt12_dac_fifo.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/jt12_pcm_pkg.sv
// Shared constants and sample conversion for the YM2612 DAC path.
// Exports PCM_W, DAC_W, DEFAULT_DEPTH and dac_conv().
package jt12_pcm_pkg;

  localparam int PCM_W         = 9;
  localparam int DAC_W         = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Offset-binary byte to signed 9-bit: flip MSB, scale by 2.
  function automatic logic [PCM_W-1:0] dac_conv(
    input logic [DAC_W-1:0] d
  );
    return {~d[7], d[6:0], 1'b0};
  endfunction

endpackage

// File: rtl/jt12_dac_fifo_mem.sv
// DAC sample storage: DEPTH entries, sync write, registered read.
// Ports: clk, rst, i_push, i_pop, i_flush, i_wdata -> o_rdata, o_level.
module jt12_dac_fifo_mem
  import jt12_pcm_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int LW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [PCM_W-1:0] i_wdata,
  output logic [PCM_W-1:0] o_rdata,
  output logic [LW-1:0]    o_level
);

  localparam int AW = LW - 1;

  logic [PCM_W-1:0] r_mem [DEPTH];
  logic [LW-1:0]    r_wcnt;
  logic [LW-1:0]    r_rcnt;
  logic [PCM_W-1:0] r_rdata;
  logic [AW-1:0]    w_wptr;
  logic [AW-1:0]    w_rptr;

  // Counters run modulo 2*DEPTH; their low bits are the pointers.
  assign w_wptr  = r_wcnt[AW-1:0];
  assign w_rptr  = r_rcnt[AW-1:0];
  assign o_level = r_wcnt - r_rcnt;
  assign o_rdata = r_rdata;

  always_ff @(posedge clk) begin
    if (i_push && !rst && !i_flush)
      r_mem[w_wptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wcnt  <= '0;
      r_rcnt  <= '0;
      r_rdata <= '0;
    end else begin
      if (i_push)
        r_wcnt <= r_wcnt + 1'b1;
      if (i_pop) begin
        r_rcnt  <= r_rcnt + 1'b1;
        r_rdata <= r_mem[w_rptr];
      end
    end
  end

endmodule

// File: rtl/jt12_dac_fifo.sv
// YM2612 DAC sample FIFO: CPU pushes 0x2A bytes, zero edges pop.
// Ports: clk, rst, clk_en, cpu_*, dacen_*, clr_flags, zero -> pcm,
// pcm_wr, dac_en, level, ovf, udf.
module jt12_dac_fifo
  import jt12_pcm_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int LW    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic [DAC_W-1:0]        cpu_din,
  input  logic                    cpu_wr,
  input  logic                    dacen_wr,
  input  logic                    dacen_din,
  input  logic                    clr_flags,
  input  logic                    zero,
  output logic signed [PCM_W-1:0] pcm,
  output logic                    pcm_wr,
  output logic                    dac_en,
  output logic [LW-1:0]           level,
  output logic                    ovf,
  output logic                    udf
);

  logic             r_last_zero;
  logic             r_dac_en;
  logic             r_pcm_wr;
  logic             r_ovf;
  logic             r_udf;

  logic             w_slot;
  logic             w_wr;
  logic             w_pop_req;
  logic             w_pop;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic             w_flush;
  logic             w_ovf_set;
  logic             w_udf_set;
  logic             w_clr;
  logic [LW-1:0]    w_level;
  logic [PCM_W-1:0] w_rdata;

  assign w_slot    = zero && !r_last_zero;
  assign w_full    = (w_level == LW'(DEPTH));
  assign w_empty   = (w_level == '0);
  assign w_wr      = clk_en && cpu_wr && r_dac_en;
  assign w_pop_req = w_slot && r_dac_en;
  assign w_pop     = w_pop_req && !w_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_push    = w_wr && (!w_full || w_pop);
  assign w_ovf_set = w_wr && w_full && !w_pop;
  assign w_udf_set = w_pop_req && w_empty;
  assign w_clr     = clk_en && clr_flags;
  // Disabling the DAC drops queued samples and zeroes the output.
  assign w_flush   = clk_en && dacen_wr
                  && !dacen_din && r_dac_en;

  jt12_dac_fifo_mem #(
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata (dac_conv(cpu_din)),
    .o_rdata (w_rdata),
    .o_level (w_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_zero <= 1'b1;
      r_dac_en    <= 1'b0;
      r_pcm_wr    <= 1'b0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else begin
      r_last_zero <= zero;
      r_pcm_wr    <= w_pop && !w_flush;
      if (clk_en && dacen_wr)
        r_dac_en <= dacen_din;
      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (w_clr)
        r_ovf <= 1'b0;
      if (w_udf_set)
        r_udf <= 1'b1;
      else if (w_clr)
        r_udf <= 1'b0;
    end
  end

  assign pcm    = w_rdata;
  assign pcm_wr = r_pcm_wr;
  assign dac_en = r_dac_en;
  assign level  = w_level;
  assign ovf    = r_ovf;
  assign udf    = r_udf;

endmodule

// File: tb/tb_jt12_dac_fifo.sv
// Randomized self-checking bench for jt12_dac_fifo.
// Compares every cycle against a queue-based reference model.
module tb_jt12_dac_fifo;

  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              clk_en;
  logic [7:0]        cpu_din;
  logic              cpu_wr;
  logic              dacen_wr;
  logic              dacen_din;
  logic              clr_flags;
  logic              zero;
  logic signed [8:0] pcm;
  logic              pcm_wr;
  logic              dac_en;
  logic [LW-1:0]     level;
  logic              ovf;
  logic              udf;

  int n_chk = 0;
  int n_err = 0;

  int q[$];
  int m_pcm;
  int m_wr;
  int m_en;
  int m_ovf;
  int m_udf;
  int m_lz;

  jt12_dac_fifo #(
    .DEPTH (DEPTH),
    .LW    (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .cpu_din   (cpu_din),
    .cpu_wr    (cpu_wr),
    .dacen_wr  (dacen_wr),
    .dacen_din (dacen_din),
    .clr_flags (clr_flags),
    .zero      (zero),
    .pcm       (pcm),
    .pcm_wr    (pcm_wr),
    .dac_en    (dac_en),
    .level     (level),
    .ovf       (ovf),
    .udf       (udf)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input logic signed [31:0] got,
    input logic signed [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: byte b maps to 2*(b-128).
  task automatic model();
    int slot, wr, preq, pop, full, oset, uset, dis;
    if (rst) begin
      q.delete();
      m_pcm = 0; m_wr = 0; m_en = 0;
      m_ovf = 0; m_udf = 0; m_lz = 1;
      return;
    end
    slot = zero && !m_lz;
    m_lz = zero;
    wr   = clk_en && cpu_wr && m_en;
    preq = slot && m_en;
    pop  = preq && q.size() > 0;
    full = q.size() == DEPTH;
    oset = wr && full && !pop;
    uset = preq && q.size() == 0;
    dis  = clk_en && dacen_wr && !dacen_din && m_en;
    m_wr = 0;
    if (pop) begin
      m_pcm = q.pop_front();
      m_wr  = 1;
    end
    if (wr && (!full || pop))
      q.push_back(2 * (int'(cpu_din) - 128));
    if (dis) begin
      q.delete();
      m_pcm = 0;
      m_wr  = 0;
    end
    if (clk_en && clr_flags) begin
      m_ovf = 0;
      m_udf = 0;
    end
    if (oset) m_ovf = 1;
    if (uset) m_udf = 1;
    if (clk_en && dacen_wr) m_en = dacen_din;
  endtask

  task automatic step(
    input bit r, input bit ce, input bit wr,
    input bit [7:0] d, input bit dw, input bit dd,
    input bit clr, input bit z
  );
    rst = r; clk_en = ce; cpu_wr = wr;
    cpu_din = d; dacen_wr = dw; dacen_din = dd;
    clr_flags = clr; zero = z;
    @(posedge clk);
    model();
    #1;
    chk("pcm", pcm, m_pcm);
    chk("pcm_wr", pcm_wr, m_wr);
    chk("level", level, q.size());
    chk("dac_en", dac_en, m_en);
    chk("ovf", ovf, m_ovf);
    chk("udf", udf, m_udf);
  endtask

  task automatic idle(input bit z);
    step(0, 1, 0, 8'h00, 0, 0, 0, z);
  endtask

  task automatic push(input bit [7:0] d);
    step(0, 1, 1, d, 0, 0, 0, 0);
  endtask

  task automatic slot();
    step(0, 1, 0, 8'h00, 0, 0, 0, 1);
    idle(0);
  endtask

  task automatic enable(input bit e);
    step(0, 1, 0, 8'h00, 1, e, 0, 0);
  endtask

  task automatic do_reset(input bit z);
    step(1, 0, 0, 8'h00, 0, 0, 0, z);
    step(1, 0, 0, 8'h00, 0, 0, 0, z);
  endtask

  initial begin
    bit zr;
    do_reset(0);

    // Conversion and ordering
    enable(1);
    push(8'h80); push(8'hFF); push(8'h00);
    chk("lvl3", level, 3);
    slot(); slot(); slot();
    chk("lvl0", level, 0);

    // Overflow: fifth byte dropped
    do_reset(0);
    enable(1);
    for (int i = 1; i <= 5; i++) push(8'(8'h10 * i));
    chk("full", level, DEPTH);
    repeat (4) slot();

    // Underflow after +254, then clear
    push(8'hFF); slot(); slot();
    step(0, 1, 0, 8'h00, 0, 0, 1, 0);

    // Push and pop together while full
    for (int i = 0; i < 4; i++) push(8'(8'hA0 + i));
    step(0, 1, 1, 8'hB5, 0, 0, 0, 1);
    idle(0);
    repeat (5) slot();

    // Push and pop together while empty
    step(0, 1, 1, 8'h33, 0, 0, 0, 1);
    idle(0); slot();

    // Disable flush
    push(8'h11); push(8'h22); push(8'h33);
    enable(0);
    push(8'h44);
    slot();

    // Reset with zero held high
    enable(1);
    push(8'h55); push(8'h66);
    idle(1);
    do_reset(1);
    repeat (3) idle(1);
    idle(0); idle(1); idle(0);

    // Randomized phase
    do_reset(0);
    zr = 0;
    for (int i = 0; i < 3000; i++) begin
      bit ce, wr, dw, dd, clr, r;
      int zp;
      zp  = (i < 1000) ? 6 : (i < 2000) ? 2 : 4;
      ce  = $urandom_range(0, 3) != 0;
      wr  = $urandom_range(0, 1) == 0;
      dw  = $urandom_range(0, 39) == 0;
      dd  = $urandom_range(0, 3) != 0;
      clr = $urandom_range(0, 29) == 0;
      r   = $urandom_range(0, 499) == 0;
      if ($urandom_range(0, zp - 1) == 0) zr = ~zr;
      step(r, ce, wr, 8'($urandom), dw, dd, clr, zr);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
